branch_predictor_gshare: RTL and testbench
==========================================

# branch_predictor_gshare

Parametrised dynamic branch predictor, successor to the fixed 2-bit branch history table. It holds a table of saturating counters indexed by low PC bits, optionally XOR-ed with a global history register (gshare mode). Fetch does a lookup and gets a registered prediction one cycle later. Execute writes back resolved outcomes. The block also keeps saturating lookup and mispredict counters for performance reporting.

## Interface
Parameters:
- INDEX_BITS, 5, table index width; depth = 2**INDEX_BITS counters
- HIST_BITS, 5, global history length; legal range 1..INDEX_BITS
- CTR_BITS, 2, counter width per entry; legal range 2..4
- GSHARE, 1, 1 = index is PC XOR history; 0 = bimodal (PC only, history still tracked)

Ports:
- clk  in  1  clock, rising edge
- arst_n  in  1  reset; asynchronous, active-low
- en  in  1  global enable; when 0, no state changes and all outputs hold
- lookup_valid  in  1  fetch requests a prediction this cycle
- lookup_pc  in  INDEX_BITS  low PC bits of the instruction being fetched
- pred_valid  out  1  registered; prediction/pred_index are valid
- prediction  out  1  registered; 1 = predict taken
- pred_index  out  INDEX_BITS  registered table index used; carried down the pipeline and returned as update_index
- update_valid  in  1  a branch or jump resolved this cycle
- update_index  in  INDEX_BITS  index returned from pred_index
- update_taken  in  1  resolved outcome; unconditional jumps drive 1
- update_mispredict  in  1  resolved outcome differed from the prediction
- flush  in  1  clear global history (pipeline redirect or context switch)
- perf_clr  in  1  synchronous clear of both perf counters
- perf_lookups  out  16  saturating count of accepted lookups
- perf_mispredicts  out  16  saturating count of accepted mispredict updates

## Operation
- Reset (arst_n=0, async):
  - every counter is set to 2**(CTR_BITS-1)-1 (weakly not-taken; 01 for CTR_BITS=2)
  - ghr is set to 0
  - pred_valid, prediction and pred_index are 0
  - both perf counters are 0
- Index:
  - idx = lookup_pc ^ {zero-pad, ghr} when GSHARE=1
  - idx = lookup_pc when GSHARE=0
  - ghr is right-aligned into the low HIST_BITS of the index
- Lookup (en=1):
  - pred_valid <= lookup_valid
  - when lookup_valid=1: prediction <= MSB of ctr[idx] and pred_index <= idx
  - when lookup_valid=0: prediction and pred_index hold their previous values
- Update (en=1, update_valid=1):
  - update_taken=1: ctr[update_index] <= min(ctr+1, 2**CTR_BITS-1)
  - update_taken=0: ctr[update_index] <= max(ctr-1, 0)
  - ghr <= {ghr[HIST_BITS-2:0], update_taken}; for HIST_BITS=1, ghr <= update_taken
- Flush (en=1, flush=1): ghr <= 0. Flush takes priority over the history shift. A simultaneous counter update still occurs.
- Perf counters (en=1):
  - perf_lookups increments on lookup_valid
  - perf_mispredicts increments on update_valid & update_mispredict
  - both hold at 16'hFFFF (saturate, no wrap)
  - perf_clr=1 forces 0 and overrides any increment in the same cycle
- en=0:
  - counters, ghr, perf counters and all registered outputs hold
  - pred_valid also holds

## Timing
- Lookup latency is 1 cycle: a request sampled at edge N appears on the outputs after edge N.
- Throughput: one lookup and one update per cycle, concurrently.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update counter (read-before-write, no bypass). A lookup in the next cycle sees the new value.
- A lookup in the same cycle as an update or flush uses the old ghr. The new ghr affects lookups from the next cycle on.
- No backpressure; pred_valid is a single-cycle qualifier, not a handshake.
- Reset asserted mid-operation clears all state immediately. The first lookup after deassertion predicts not-taken.

## Test plan
- Reset, then lookup_pc=3 (GSHARE=0) -> next cycle pred_valid=1, prediction=0, pred_index=3; perf_lookups=1.
- Two taken updates to index 3 with no lookup in between, then lookup_pc=3 -> prediction=1 (counter 01->10->11). A third taken update keeps the counter at 11. One not-taken update gives 10 and still predicts 1. A second not-taken update gives 01 and predicts 0.
- GSHARE=1, updates taken, taken, not-taken (ghr=00110), then lookup_pc=5'b00101 -> pred_index=5'b00011. Asserting flush with update_valid in the same cycle leaves ghr=0 while the counter still updates.
- Same cycle: lookup_pc=7 and update_index=7 taken, starting from counter 01 -> prediction=0. The lookup in the following cycle -> prediction=1.
- perf_mispredicts preloaded by 65535 mispredict updates -> one more update leaves it at 16'hFFFF. perf_clr together with an increment -> 0.
- en=0 with lookup_valid/update_valid/flush all active -> no counter, ghr, perf or output change. Reset pulsed mid-stream -> all outputs are 0 and counters return to weakly not-taken.

Source files
------------

// File: rtl/branch_predictor_gshare_if.sv
// Bundle between fetch/execute and the gshare branch predictor.
// The master side (pipeline) drives lookup, update, flush, enable and perf-clear
// requests. The slave side (predictor) returns the registered prediction and
// the perf counters. Clock and reset stay outside the bundle.
interface branch_predictor_gshare_if #(
    parameter int unsigned INDEX_BITS = 5
) ();
    logic                  en;
    logic                  lookup_valid;
    logic [INDEX_BITS-1:0] lookup_pc;
    logic                  pred_valid;
    logic                  prediction;
    logic [INDEX_BITS-1:0] pred_index;
    logic                  update_valid;
    logic [INDEX_BITS-1:0] update_index;
    logic                  update_taken;
    logic                  update_mispredict;
    logic                  flush;
    logic                  perf_clr;
    logic [15:0]           perf_lookups;
    logic [15:0]           perf_mispredicts;

    modport master (
        output en, lookup_valid, lookup_pc, update_valid, update_index, update_taken,
               update_mispredict, flush, perf_clr,
        input  pred_valid, prediction, pred_index, perf_lookups, perf_mispredicts
    );

    modport slave (
        input  en, lookup_valid, lookup_pc, update_valid, update_index, update_taken,
               update_mispredict, flush, perf_clr,
        output pred_valid, prediction, pred_index, perf_lookups, perf_mispredicts
    );
endinterface

// File: rtl/branch_predictor_gshare.sv
// Dynamic branch predictor: a table of saturating counters indexed by low PC
// bits, optionally XOR-ed with a global history register (gshare mode).
// Ports:
//   clk    - clock, rising edge
//   arst_n - asynchronous active-low reset
//   bp_io  - slave side of branch_predictor_gshare_if:
//            lookup request in, registered prediction/index out (1-cycle latency),
//            resolved-branch update in, history flush, enable, perf counters.
module branch_predictor_gshare #(
    parameter int unsigned INDEX_BITS = 5,
    parameter int unsigned HIST_BITS  = 5,
    parameter int unsigned CTR_BITS   = 2,
    parameter int unsigned GSHARE     = 1
) (
    input logic                      clk,
    input logic                      arst_n,
    branch_predictor_gshare_if.slave bp_io
);
    localparam int unsigned Depth = 2 ** INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CtrMax  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CtrInit = CtrMax >> 1; // weakly not-taken

    if (HIST_BITS < 1 || HIST_BITS > INDEX_BITS) begin : g_bad_hist
        $error("HIST_BITS must be in 1..INDEX_BITS");
    end
    if (CTR_BITS < 2 || CTR_BITS > 4) begin : g_bad_ctr
        $error("CTR_BITS must be in 2..4");
    end

    logic [CTR_BITS-1:0]   ctr_q [Depth];
    logic [CTR_BITS-1:0]   ctr_d [Depth];
    logic [HIST_BITS-1:0]  ghr_q, ghr_d;
    logic                  pred_valid_q, pred_valid_d;
    logic                  prediction_q, prediction_d;
    logic [INDEX_BITS-1:0] pred_index_q, pred_index_d;
    logic [15:0]           lookups_q, lookups_d;
    logic [15:0]           mispredicts_q, mispredicts_d;

    logic [INDEX_BITS-1:0] lookup_idx;
    logic [CTR_BITS-1:0]   upd_ctr;

    // History is right-aligned into the low index bits.
    always_comb begin
        lookup_idx = bp_io.lookup_pc;
        if (GSHARE != 0) begin
            lookup_idx = bp_io.lookup_pc ^ INDEX_BITS'(ghr_q);
        end
    end

    assign upd_ctr = ctr_q[bp_io.update_index];

    // Counter table: reads in this cycle see the pre-update value (no bypass).
    always_comb begin
        ctr_d = ctr_q;
        if (bp_io.en && bp_io.update_valid) begin
            if (bp_io.update_taken) begin
                if (upd_ctr != CtrMax) begin
                    ctr_d[bp_io.update_index] = upd_ctr + CTR_BITS'(1);
                end
            end else if (upd_ctr != '0) begin
                ctr_d[bp_io.update_index] = upd_ctr - CTR_BITS'(1);
            end
        end
    end

    // Flush beats the shift; truncating the concatenation drops the oldest bit.
    always_comb begin
        ghr_d = ghr_q;
        if (bp_io.en) begin
            if (bp_io.flush) begin
                ghr_d = '0;
            end else if (bp_io.update_valid) begin
                ghr_d = HIST_BITS'({ghr_q, bp_io.update_taken});
            end
        end
    end

    always_comb begin
        pred_valid_d = pred_valid_q;
        prediction_d = prediction_q;
        pred_index_d = pred_index_q;
        if (bp_io.en) begin
            pred_valid_d = bp_io.lookup_valid;
            if (bp_io.lookup_valid) begin
                prediction_d = ctr_q[lookup_idx][CTR_BITS-1];
                pred_index_d = lookup_idx;
            end
        end
    end

    // Perf counters saturate; clear overrides a same-cycle increment.
    always_comb begin
        lookups_d     = lookups_q;
        mispredicts_d = mispredicts_q;
        if (bp_io.en) begin
            if (bp_io.perf_clr) begin
                lookups_d     = '0;
                mispredicts_d = '0;
            end else begin
                if (bp_io.lookup_valid && lookups_q != 16'hFFFF) begin
                    lookups_d = lookups_q + 16'd1;
                end
                if (bp_io.update_valid && bp_io.update_mispredict &&
                    mispredicts_q != 16'hFFFF) begin
                    mispredicts_d = mispredicts_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < Depth; i++) begin
                ctr_q[i] <= CtrInit;
            end
            ghr_q         <= '0;
            pred_valid_q  <= 1'b0;
            prediction_q  <= 1'b0;
            pred_index_q  <= '0;
            lookups_q     <= '0;
            mispredicts_q <= '0;
        end else begin
            ctr_q         <= ctr_d;
            ghr_q         <= ghr_d;
            pred_valid_q  <= pred_valid_d;
            prediction_q  <= prediction_d;
            pred_index_q  <= pred_index_d;
            lookups_q     <= lookups_d;
            mispredicts_q <= mispredicts_d;
        end
    end

    assign bp_io.pred_valid       = pred_valid_q;
    assign bp_io.prediction       = prediction_q;
    assign bp_io.pred_index       = pred_index_q;
    assign bp_io.perf_lookups     = lookups_q;
    assign bp_io.perf_mispredicts = mispredicts_q;
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Bench for branch_predictor_gshare: one bimodal (GSHARE=0) and one gshare
// (GSHARE=1) instance share the same stimulus. Expected predictions are pushed
// into a per-instance queue when a lookup is issued; a monitor per instance
// pops and compares whenever pred_valid is seen.
module tb_branch_predictor_gshare;
    typedef struct packed {
        logic       pred;
        logic [4:0] idx;
    } exp_t;

    logic clk = 1'b0;
    logic arst_n;
    always #5 clk = ~clk;

    logic       en, lv, uv, ut, um, fl, pclr;
    logic [4:0] lpc, uidx;

    int checks = 0;
    int errors = 0;
    int exp_lookups = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    branch_predictor_gshare_if #(.INDEX_BITS(5)) bus0 ();
    branch_predictor_gshare_if #(.INDEX_BITS(5)) bus1 ();

    assign bus0.en = en;               assign bus1.en = en;
    assign bus0.lookup_valid = lv;     assign bus1.lookup_valid = lv;
    assign bus0.lookup_pc = lpc;       assign bus1.lookup_pc = lpc;
    assign bus0.update_valid = uv;     assign bus1.update_valid = uv;
    assign bus0.update_index = uidx;   assign bus1.update_index = uidx;
    assign bus0.update_taken = ut;     assign bus1.update_taken = ut;
    assign bus0.update_mispredict = um; assign bus1.update_mispredict = um;
    assign bus0.flush = fl;            assign bus1.flush = fl;
    assign bus0.perf_clr = pclr;       assign bus1.perf_clr = pclr;

    branch_predictor_gshare #(
        .INDEX_BITS(5), .HIST_BITS(5), .CTR_BITS(2), .GSHARE(0)
    ) dut_bim (
        .clk    (clk),
        .arst_n (arst_n),
        .bp_io  (bus0)
    );

    branch_predictor_gshare #(
        .INDEX_BITS(5), .HIST_BITS(5), .CTR_BITS(2), .GSHARE(1)
    ) dut_gsh (
        .clk    (clk),
        .arst_n (arst_n),
        .bp_io  (bus1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus0.pred_valid === 1'b1) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL bim_unexpected: got pred_valid=1, expected no prediction");
            end else begin
                e0 = q0.pop_front();
                if ({bus0.prediction, bus0.pred_index} !== e0) begin
                    errors++;
                    $display("FAIL bim_pred: got pred=%0b idx=%0d, expected pred=%0b idx=%0d",
                             bus0.prediction, bus0.pred_index, e0.pred, e0.idx);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus1.pred_valid === 1'b1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL gsh_unexpected: got pred_valid=1, expected no prediction");
            end else begin
                e1 = q1.pop_front();
                if ({bus1.prediction, bus1.pred_index} !== e1) begin
                    errors++;
                    $display("FAIL gsh_pred: got pred=%0b idx=%0d, expected pred=%0b idx=%0d",
                             bus1.prediction, bus1.pred_index, e1.pred, e1.idx);
                end
            end
        end
    end

    task automatic idle();
        en = 1'b1; lv = 1'b0; lpc = '0; uv = 1'b0; uidx = '0;
        ut = 1'b0; um = 1'b0; fl = 1'b0; pclr = 1'b0;
    endtask

    task automatic push(input logic p0, input logic [4:0] i0,
                        input logic p1, input logic [4:0] i1);
        q0.push_back('{pred: p0, idx: i0});
        q1.push_back('{pred: p1, idx: i1});
    endtask

    // Expected values: (bimodal pred, idx), (gshare pred, idx).
    task automatic set_look(input logic [4:0] pc, input logic p0, input logic [4:0] i0,
                            input logic p1, input logic [4:0] i1);
        lv = 1'b1;
        lpc = pc;
        push(p0, i0, p1, i1);
        exp_lookups++;
    endtask

    task automatic set_upd(input logic [4:0] idx, input logic t, input logic m,
                           input logic f);
        uv = 1'b1; uidx = idx; ut = t; um = m; fl = f;
    endtask

    task automatic cycle();
        @(negedge clk);
        idle();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_bim_valid"}, 32'(bus0.pred_valid), 32'd0);
        check({tag, "_bim_pred"}, 32'(bus0.prediction), 32'd0);
        check({tag, "_bim_idx"}, 32'(bus0.pred_index), 32'd0);
        check({tag, "_bim_lookups"}, 32'(bus0.perf_lookups), 32'd0);
        check({tag, "_gsh_valid"}, 32'(bus1.pred_valid), 32'd0);
        check({tag, "_gsh_idx"}, 32'(bus1.pred_index), 32'd0);
        check({tag, "_gsh_mispredicts"}, 32'(bus1.perf_mispredicts), 32'd0);
    endtask

    initial begin
        arst_n = 1'b0;
        idle();
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);

        // First lookup after reset: counter 01 -> not taken.
        set_look(5'd3, 1'b0, 5'd3, 1'b0, 5'd3); cycle();
        check("perf_lookups_one", 32'(bus0.perf_lookups), 32'd1);

        // Saturating counter walk on index 3; flush keeps ghr at 0.
        set_upd(5'd3, 1'b1, 1'b0, 1'b1); cycle();
        set_upd(5'd3, 1'b1, 1'b0, 1'b1); cycle();
        set_look(5'd3, 1'b1, 5'd3, 1'b1, 5'd3); cycle();   // 11
        set_upd(5'd3, 1'b1, 1'b0, 1'b1); cycle();
        set_look(5'd3, 1'b1, 5'd3, 1'b1, 5'd3); cycle();   // stays 11
        set_upd(5'd3, 1'b0, 1'b0, 1'b1); cycle();
        set_look(5'd3, 1'b1, 5'd3, 1'b1, 5'd3); cycle();   // 10
        set_upd(5'd3, 1'b0, 1'b0, 1'b1); cycle();
        set_look(5'd3, 1'b0, 5'd3, 1'b0, 5'd3); cycle();   // 01

        // History T,T,N -> ghr=00110; ctr[3] 01->10->11->10.
        set_upd(5'd3, 1'b1, 1'b0, 1'b0); cycle();
        set_upd(5'd3, 1'b1, 1'b0, 1'b0); cycle();
        set_upd(5'd3, 1'b0, 1'b0, 1'b0); cycle();
        set_look(5'd5, 1'b0, 5'd5, 1'b1, 5'd3); cycle();   // gshare idx 00101^00110
        // Flush with update: ghr cleared, ctr[3] 10->11.
        set_upd(5'd3, 1'b1, 1'b0, 1'b1); cycle();
        set_look(5'd5, 1'b0, 5'd5, 1'b0, 5'd5); cycle();
        set_look(5'd3, 1'b1, 5'd3, 1'b1, 5'd3); cycle();
        // Same-cycle update uses old ghr; next lookup sees ghr=00001.
        set_look(5'd5, 1'b0, 5'd5, 1'b0, 5'd5); set_upd(5'd9, 1'b1, 1'b0, 1'b0); cycle();
        set_look(5'd5, 1'b0, 5'd5, 1'b0, 5'd4); cycle();
        fl = 1'b1; cycle();

        // Read-before-write on index 7 (01 -> 10).
        set_look(5'd7, 1'b0, 5'd7, 1'b0, 5'd7); set_upd(5'd7, 1'b1, 1'b0, 1'b1); cycle();
        set_look(5'd7, 1'b1, 5'd7, 1'b1, 5'd7); cycle();

        // Leave ghr=00001 and a valid prediction (1,7), then freeze.
        set_look(5'd7, 1'b1, 5'd7, 1'b1, 5'd7); set_upd(5'd25, 1'b1, 1'b0, 1'b0); cycle();
        en = 1'b0; lv = 1'b1; lpc = 5'd3; uv = 1'b1; uidx = 5'd7; ut = 1'b0;
        um = 1'b1; fl = 1'b1; pclr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(1'b1, 5'd7, 1'b1, 5'd7);
            @(negedge clk);
        end
        idle();
        check("en0_bim_lookups", 32'(bus0.perf_lookups), 32'(exp_lookups));
        check("en0_gsh_lookups", 32'(bus1.perf_lookups), 32'(exp_lookups));
        check("en0_mispredicts", 32'(bus1.perf_mispredicts), 32'd0);
        // ctr[7] still 10 and ghr still 00001.
        set_look(5'd6, 1'b0, 5'd6, 1'b1, 5'd7); cycle();
        set_look(5'd5, 1'b0, 5'd5, 1'b0, 5'd4); cycle();
        set_look(5'd7, 1'b1, 5'd7, 1'b0, 5'd6); cycle();

        // Mispredict counter saturation.
        for (int i = 0; i < 65535; i++) begin
            set_upd(5'd31, 1'b0, 1'b1, 1'b1); cycle();
        end
        check("mis_at_max", 32'(bus0.perf_mispredicts), 32'hFFFF);
        set_upd(5'd31, 1'b0, 1'b1, 1'b1); cycle();
        check("mis_saturate_bim", 32'(bus0.perf_mispredicts), 32'hFFFF);
        check("mis_saturate_gsh", 32'(bus1.perf_mispredicts), 32'hFFFF);
        set_look(5'd0, 1'b0, 5'd0, 1'b0, 5'd0); set_upd(5'd31, 1'b0, 1'b1, 1'b1);
        pclr = 1'b1; cycle();
        check("clr_mis", 32'(bus0.perf_mispredicts), 32'd0);
        check("clr_lookups", 32'(bus1.perf_lookups), 32'd0);

        // Reset mid-stream: outputs drop at once, counters back to 01.
        set_look(5'd3, 1'b1, 5'd3, 1'b1, 5'd3); cycle();
        #2 arst_n = 1'b0;
        #1 check_outputs_zero("midreset");
        @(negedge clk);
        arst_n = 1'b1;
        set_look(5'd3, 1'b0, 5'd3, 1'b0, 5'd3); cycle();

        repeat (3) @(negedge clk);
        check("bim_queue_drained", 32'(q0.size()), 32'd0);
        check("gsh_queue_drained", 32'(q1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
